// File: rtl/cpu_decode_q.sv
// cpu_decode_q: queued, handshaked instruction decode stage sitting between fetch and execute.
// Define CPU_DECODE_STATS_EN to add the stat_decoded_o / stat_stall_o event counters.

`ifndef CPU_DECODE_Q_DEFS
`define CPU_DECODE_Q_DEFS
`define PCB_WIDTH 8
// Form-1 ops use their own opcode[13:8] value; form-2/3 ops reuse unassigned form-1 slots.
`define OP_NOP    6'h00
`define OP_LDI_L  6'h01
`define OP_MOV    6'h02
`define OP_JSRA   6'h03
`define OP_RET    6'h04
`define OP_ADD_L  6'h05
`define OP_PUSH   6'h06
`define OP_POP    6'h07
`define OP_LDA_L  6'h08
`define OP_STA_L  6'h09
`define OP_LD_L   6'h0a
`define OP_ST_L   6'h0b
`define OP_LDO_L  6'h0c
`define OP_STO_L  6'h0d
`define OP_CMP    6'h0e
`define OP_BAD    6'h0f
`define OP_SEX_B  6'h10
`define OP_SEX_S  6'h11
`define OP_ZEX_B  6'h12
`define OP_ZEX_S  6'h13
`define OP_INC    6'h14
`define OP_DEC    6'h15
`define OP_GSR    6'h16
`define OP_SSR    6'h17
`define OP_JSR    6'h19
`define OP_JMPA   6'h1a
`define OP_LDI_B  6'h1b
`define OP_LD_B   6'h1c
`define OP_LDA_B  6'h1d
`define OP_ST_B   6'h1e
`define OP_STA_B  6'h1f
`define OP_LDI_S  6'h20
`define OP_LD_S   6'h21
`define OP_LDA_S  6'h22
`define OP_ST_S   6'h23
`define OP_STA_S  6'h24
`define OP_JMP    6'h25
`define OP_AND    6'h26
`define OP_LSHR   6'h27
`define OP_ASHL   6'h28
`define OP_SUB_L  6'h29
`define OP_NEG    6'h2a
`define OP_OR     6'h2b
`define OP_NOT    6'h2c
`define OP_ASHR   6'h2d
`define OP_XOR    6'h2e
`define OP_MUL_L  6'h2f
`define OP_BEQ    6'h30
`define OP_BNE    6'h31
`define OP_BLT    6'h32
`define OP_BGT    6'h33
`define OP_BLTU   6'h34
`define OP_BGTU   6'h35
`define OP_LDO_B  6'h36
`define OP_STO_B  6'h37
`define OP_LDO_S  6'h38
`define OP_STO_S  6'h39
`define OP_BGE    6'h3a
`define OP_BLE    6'h3b
`define OP_BGEU   6'h3c
`define OP_BLEU   6'h3d
`endif

module cpu_decode_q #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned BR_OFF_W = 10
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         stall_i,
    input  logic                         valid_i,
    input  logic [15:0]                  opcode_i,
    input  logic [31:0]                  operand_i,
    input  logic [31:0]                  PC_i,
    output logic                         ready_o,
    output logic                         valid_o,
    output logic [5:0]                   op_o,
    output logic [3:0]                   riA_o,
    output logic [3:0]                   riB_o,
    output logic [3:0]                   register_write_index_o,
    output logic [31:0]                  operand_o,
    output logic [31:0]                  PC_o,
    output logic [`PCB_WIDTH-1:0]        pipeline_control_bits_o,
    output logic                         bad_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
`ifdef CPU_DECODE_STATS_EN
    ,
    output logic [31:0]                  stat_decoded_o,
    output logic [31:0]                  stat_stall_o
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    localparam logic [`PCB_WIDTH-1:0] PcbWrA    = 'h01;
    localparam logic [`PCB_WIDTH-1:0] PcbRdA    = 'h02;
    localparam logic [`PCB_WIDTH-1:0] PcbRdB    = 'h04;
    localparam logic [`PCB_WIDTH-1:0] PcbMemRd  = 'h08;
    localparam logic [`PCB_WIDTH-1:0] PcbMemWr  = 'h10;
    localparam logic [`PCB_WIDTH-1:0] PcbBranch = 'h20;
    localparam logic [`PCB_WIDTH-1:0] PcbLong   = 'h40;
    localparam logic [`PCB_WIDTH-1:0] PcbFlags  = 'h80;

    logic [15:0]     opc_mem [DEPTH];
    logic [31:0]     opd_mem [DEPTH];
    logic [31:0]     pc_mem  [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop;

    // Ready depends on occupancy only: a full queue never accepts, even if it pops this cycle.
    assign ready_o = (count_q != CntW'(DEPTH)) && !rst_i;
    assign push    = valid_i && ready_o && !flush_i;
    assign pop     = (count_q != '0) && (!valid_o || !stall_i) && !flush_i;
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            opc_mem[wr_ptr_q] <= opcode_i;
            opd_mem[wr_ptr_q] <= operand_i;
            pc_mem[wr_ptr_q]  <= PC_i;
        end
    end

    function automatic logic [5:0] form1_op(input logic [5:0] c);
        logic [5:0] r;
        r = c;
        if (c == 6'h0f || (c >= 6'h14 && c <= 6'h18) || (c >= 6'h30 && c <= 6'h35) ||
            c >= 6'h3a) begin
            r = `OP_BAD;
        end
        return r;
    endfunction

    function automatic logic is_long(input logic [5:0] op);
        case (op)
            `OP_LDI_L, `OP_LDI_B, `OP_LDI_S, `OP_LDA_L, `OP_LDA_B, `OP_LDA_S,
            `OP_STA_L, `OP_STA_B, `OP_STA_S, `OP_LDO_L, `OP_LDO_B, `OP_LDO_S,
            `OP_STO_L, `OP_STO_B, `OP_STO_S, `OP_JMPA, `OP_JSRA: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [`PCB_WIDTH-1:0] pcb_of(input logic [5:0] op);
        logic [`PCB_WIDTH-1:0] r;
        r = '0;
        case (op)
            `OP_ADD_L, `OP_AND, `OP_LSHR, `OP_ASHL, `OP_SUB_L, `OP_OR, `OP_ASHR, `OP_XOR,
            `OP_MUL_L:                               r = PcbWrA | PcbRdA | PcbRdB;
            `OP_MOV, `OP_NEG, `OP_NOT, `OP_SEX_B, `OP_SEX_S, `OP_ZEX_B,
            `OP_ZEX_S:                               r = PcbWrA | PcbRdB;
            `OP_LDI_L, `OP_LDI_B, `OP_LDI_S:        r = PcbWrA | PcbLong;
            `OP_LDA_L, `OP_LDA_B, `OP_LDA_S:        r = PcbWrA | PcbMemRd | PcbLong;
            `OP_STA_L, `OP_STA_B, `OP_STA_S:        r = PcbRdA | PcbMemWr | PcbLong;
            `OP_LD_L, `OP_LD_B, `OP_LD_S:           r = PcbWrA | PcbRdB | PcbMemRd;
            `OP_ST_L, `OP_ST_B, `OP_ST_S, `OP_PUSH: r = PcbRdA | PcbRdB | PcbMemWr;
            `OP_LDO_L, `OP_LDO_B, `OP_LDO_S:        r = PcbWrA | PcbRdB | PcbMemRd | PcbLong;
            `OP_STO_L, `OP_STO_B, `OP_STO_S:        r = PcbRdA | PcbRdB | PcbMemWr | PcbLong;
            `OP_CMP:                                 r = PcbRdA | PcbRdB | PcbFlags;
            `OP_POP:                                 r = PcbWrA | PcbRdA | PcbMemRd;
            `OP_JSRA:                                r = PcbBranch | PcbMemWr | PcbLong;
            `OP_JMPA:                                r = PcbBranch | PcbLong;
            `OP_JSR:                                 r = PcbBranch | PcbRdA | PcbMemWr;
            `OP_JMP:                                 r = PcbBranch | PcbRdA;
            `OP_RET:                                 r = PcbBranch | PcbMemRd;
            `OP_INC, `OP_DEC:                        r = PcbWrA | PcbRdA;
            `OP_GSR:                                 r = PcbWrA;
            `OP_SSR:                                 r = PcbRdA;
            `OP_BEQ, `OP_BNE, `OP_BLT, `OP_BGT, `OP_BLTU, `OP_BGTU, `OP_BGE, `OP_BLE,
            `OP_BGEU, `OP_BLEU:                      r = PcbBranch;
            default:                                 r = '0;
        endcase
        return r;
    endfunction

    logic [15:0] h;
    logic [31:0] h_opd, h_pc, br_off, dec_operand;
    logic [5:0]  dec_op;
    logic [3:0]  dec_ria;

    assign h     = opc_mem[rd_ptr_q];
    assign h_opd = opd_mem[rd_ptr_q];
    assign h_pc  = pc_mem[rd_ptr_q];

    always_comb begin
        dec_op      = `OP_BAD;
        dec_operand = '0;
        dec_ria     = h[15] ? h[11:8] : h[7:4];
        br_off      = {{(32 - BR_OFF_W){h[BR_OFF_W-1]}}, h[BR_OFF_W-1:0]};
        if (!h[15]) begin
            dec_op = form1_op(h[13:8]);
            if (is_long(dec_op)) dec_operand = h_opd;
        end else if (!h[14]) begin
            unique case (h[13:12])
                2'd0: dec_op = `OP_INC;
                2'd1: dec_op = `OP_DEC;
                2'd2: dec_op = `OP_GSR;
                2'd3: dec_op = `OP_SSR;
            endcase
            dec_operand = {24'h0, h[7:0]};
        end else begin
            dec_operand = br_off << 1;
            case (h[13:10])
                4'd0:    dec_op = `OP_BEQ;
                4'd1:    dec_op = `OP_BNE;
                4'd2:    dec_op = `OP_BLT;
                4'd3:    dec_op = `OP_BGT;
                4'd4:    dec_op = `OP_BLTU;
                4'd5:    dec_op = `OP_BGTU;
                4'd6:    dec_op = `OP_BGE;
                4'd7:    dec_op = `OP_BLE;
                4'd8:    dec_op = `OP_BGEU;
                4'd9:    dec_op = `OP_BLEU;
                default: dec_op = `OP_BAD;
            endcase
        end
    end

    logic                  valid_q, bad_q;
    logic [5:0]            op_q;
    logic [3:0]            ria_q, rib_q;
    logic [31:0]           operand_q, pc_q;
    logic [`PCB_WIDTH-1:0] pcb_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            op_q      <= `OP_NOP;
            bad_q     <= 1'b0;
            ria_q     <= '0;
            rib_q     <= '0;
            operand_q <= '0;
            pc_q      <= '0;
            pcb_q     <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            op_q    <= `OP_NOP;
            bad_q   <= 1'b0;
        end else if (pop) begin
            valid_q   <= 1'b1;
            op_q      <= dec_op;
            bad_q     <= (dec_op == `OP_BAD);
            ria_q     <= dec_ria;
            rib_q     <= h[3:0];
            operand_q <= dec_operand;
            pc_q      <= h_pc;
            pcb_q     <= pcb_of(dec_op);
        end else if (!stall_i) begin
            // Consumed with nothing behind it: present a bubble.
            valid_q <= 1'b0;
            op_q    <= `OP_NOP;
            bad_q   <= 1'b0;
        end
    end

    assign valid_o                 = valid_q;
    assign op_o                    = op_q;
    assign bad_o                   = bad_q;
    assign riA_o                   = ria_q;
    assign riB_o                   = rib_q;
    assign register_write_index_o  = ria_q;
    assign operand_o               = operand_q;
    assign PC_o                    = pc_q;
    assign pipeline_control_bits_o = pcb_q;

`ifdef CPU_DECODE_STATS_EN
    logic [31:0] stat_decoded_q, stat_stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_decoded_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            if (pop)                stat_decoded_q <= stat_decoded_q + 32'd1;
            if (valid_q && stall_i) stat_stall_q   <= stat_stall_q + 32'd1;
        end
    end

    assign stat_decoded_o = stat_decoded_q;
    assign stat_stall_o   = stat_stall_q;
`endif

endmodule

// File: tb/tb_cpu_decode_q.sv
// Self-checking bench for cpu_decode_q: scoreboard of expected decodes, checked as each is consumed.
module tb_cpu_decode_q;

    localparam int unsigned DEPTH = 2;

    localparam logic [5:0] OpNop  = 6'h00;
    localparam logic [5:0] OpLdiL = 6'h01;
    localparam logic [5:0] OpMov  = 6'h02;
    localparam logic [5:0] OpAddL = 6'h05;
    localparam logic [5:0] OpBad  = 6'h0f;
    localparam logic [5:0] OpInc  = 6'h14;
    localparam logic [5:0] OpSsr  = 6'h17;
    localparam logic [5:0] OpBeq  = 6'h30;
    localparam logic [5:0] OpBlt  = 6'h32;
    localparam logic [5:0] OpStoS = 6'h39;
    localparam logic [5:0] OpBleu = 6'h3d;

    typedef struct packed {
        logic [15:0] opc;
        logic [31:0] opd;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [3:0]  ria;
        logic [3:0]  rib;
        logic [31:0] xopd;
        logic        bad;
        logic [7:0]  pcb;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, stall_i, valid_i;
    logic [15:0] opcode_i;
    logic [31:0] operand_i, PC_i;
    logic        ready_o, valid_o, bad_o;
    logic [5:0]  op_o;
    logic [3:0]  riA_o, riB_o, register_write_index_o;
    logic [31:0] operand_o, PC_o;
    logic [7:0]  pipeline_control_bits_o;
    logic [$clog2(DEPTH+1)-1:0] count_o;
`ifdef CPU_DECODE_STATS_EN
    logic [31:0] stat_decoded_o, stat_stall_o;
`endif

    int   total = 0;
    int   bad_cnt = 0;
    vec_t exp_q[$];
    vec_t v[9];
    vec_t bv[4];
    vec_t e;

    always #5 clk_i = ~clk_i;

    cpu_decode_q #(.DEPTH(DEPTH), .BR_OFF_W(10)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .flush_i(flush_i),
        .stall_i(stall_i),
        .valid_i(valid_i),
        .opcode_i(opcode_i),
        .operand_i(operand_i),
        .PC_i(PC_i),
        .ready_o(ready_o),
        .valid_o(valid_o),
        .op_o(op_o),
        .riA_o(riA_o),
        .riB_o(riB_o),
        .register_write_index_o(register_write_index_o),
        .operand_o(operand_o),
        .PC_o(PC_o),
        .pipeline_control_bits_o(pipeline_control_bits_o),
        .bad_o(bad_o),
        .count_o(count_o)
`ifdef CPU_DECODE_STATS_EN
        ,
        .stat_decoded_o(stat_decoded_o),
        .stat_stall_o(stat_stall_o)
`endif
    );

    function automatic vec_t mk(input logic [15:0] opc, input logic [31:0] opd,
                                input logic [31:0] pc, input logic [5:0] op,
                                input logic [3:0] ria, input logic [3:0] rib,
                                input logic [31:0] xopd, input logic bd, input logic [7:0] pcb);
        vec_t r;
        r = '{opc: opc, opd: opd, pc: pc, op: op, ria: ria, rib: rib, xopd: xopd, bad: bd,
              pcb: pcb};
        return r;
    endfunction

    // Scoreboard: an output is consumed when valid_o is high and stall_i is low at the edge.
    always @(negedge clk_i) begin
        if (!rst_i && valid_o && !stall_i) begin
            total++;
            if (exp_q.size() == 0) begin
                bad_cnt++;
                $display("FAIL unexpected_output: got op=%h pc=%h, required no output", op_o, PC_o);
            end else begin
                e = exp_q.pop_front();
                if ({op_o, riA_o, riB_o, register_write_index_o, operand_o, PC_o, bad_o,
                     pipeline_control_bits_o} !==
                    {e.op, e.ria, e.rib, e.ria, e.xopd, e.pc, e.bad, e.pcb}) begin
                    bad_cnt++;
                    $display({"FAIL decode opc=%h: got op=%h A=%h B=%h W=%h opd=%h pc=%h bad=%b ",
                              "pcb=%h, required op=%h A=%h B=%h W=%h opd=%h pc=%h bad=%b pcb=%h"},
                             e.opc, op_o, riA_o, riB_o, register_write_index_o, operand_o, PC_o,
                             bad_o, pipeline_control_bits_o, e.op, e.ria, e.rib, e.ria, e.xopd,
                             e.pc, e.bad, e.pcb);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input vec_t p, output int tries);
        logic acc;
        valid_i   = 1'b1;
        opcode_i  = p.opc;
        operand_i = p.opd;
        PC_i      = p.pc;
        tries     = 0;
        acc       = 1'b0;
        while (!acc && tries < 40) begin
            tries++;
            acc = ready_o;
            tick();
        end
        valid_i = 1'b0;
        if (acc) begin
            exp_q.push_back(p);
        end else begin
            total++;
            bad_cnt++;
            $display("FAIL push_timeout opc=%h: ready_o stayed %b, required 1", p.opc, ready_o);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        valid_i = 1'b0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad_cnt++;
            $display("FAIL %s_drain: %0d outputs missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0; valid_i = 1'b0;
        opcode_i = '0; operand_i = '0; PC_i = '0;
        #1 rst_i = 1'b1;
        #2;
        total += 4;
        if (ready_o !== 1'b0) begin bad_cnt++; $display("FAIL reset_ready: got %b, required 0", ready_o); end
        if (count_o !== '0) begin bad_cnt++; $display("FAIL reset_count: got %0d, required 0", count_o); end
        if ({valid_o, bad_o, op_o} !== {1'b0, 1'b0, OpNop}) begin
            bad_cnt++;
            $display("FAIL reset_valid_op: got valid=%b bad=%b op=%h, required 0 0 %h", valid_o, bad_o, op_o, OpNop);
        end
        if ({riA_o, riB_o, register_write_index_o, operand_o, PC_o, pipeline_control_bits_o} !== '0) begin
            bad_cnt++;
            $display("FAIL reset_fields: got A=%h B=%h opd=%h pc=%h pcb=%h, required all 0",
                     riA_o, riB_o, operand_o, PC_o, pipeline_control_bits_o);
        end
        repeat (2) tick();
        rst_i = 1'b0;
        #1;
        total++;
        if (ready_o !== 1'b1) begin bad_cnt++; $display("FAIL post_reset_ready: got %b, required 1", ready_o); end
    endtask

    task automatic test_decode();
        int t;
        for (int i = 0; i < 9; i++) push(v[i], t);
        drain("decode");
        total++;
        if ({valid_o, op_o, bad_o} !== {1'b0, OpNop, 1'b0}) begin
            bad_cnt++;
            $display("FAIL bubble: got valid=%b op=%h bad=%b, required 0 %h 0", valid_o, op_o, bad_o, OpNop);
        end
    endtask

    task automatic test_stall_fill();
        int t;
        stall_i = 1'b1;
        push(v[0], t);
        push(v[1], t);
        push(v[2], t);
        valid_i = 1'b1; opcode_i = v[3].opc; operand_i = v[3].opd; PC_i = v[3].pc;
        for (int c = 0; c < 3; c++) begin
            total += 3;
            if (count_o !== 2'd2) begin bad_cnt++; $display("FAIL stall_count c=%0d: got %0d, required 2", c, count_o); end
            if (ready_o !== 1'b0) begin bad_cnt++; $display("FAIL stall_ready c=%0d: got %b, required 0", c, ready_o); end
            if ({valid_o, op_o, PC_o} !== {1'b1, v[0].op, v[0].pc}) begin
                bad_cnt++;
                $display("FAIL stall_frozen c=%0d: got valid=%b op=%h pc=%h, required 1 %h %h",
                         c, valid_o, op_o, PC_o, v[0].op, v[0].pc);
            end
            tick();
        end
        stall_i = 1'b0;
        push(v[3], t);
        total++;
        if (t !== 2) begin bad_cnt++; $display("FAIL stall_release_accept: got %0d cycles, required 2", t); end
        drain("stall");
    endtask

    task automatic test_flush();
        int t;
        stall_i = 1'b1;
        push(v[4], t);
        push(v[5], t);
        push(v[6], t);
        total++;
        if ({count_o, valid_o} !== {2'd2, 1'b1}) begin
            bad_cnt++;
            $display("FAIL preflush: got count=%0d valid=%b, required 2 1", count_o, valid_o);
        end
        flush_i = 1'b1; valid_i = 1'b1;
        opcode_i = v[7].opc; operand_i = v[7].opd; PC_i = v[7].pc;
        tick();
        flush_i = 1'b0; valid_i = 1'b0;
        exp_q.delete();
        total += 2;
        if ({count_o, ready_o} !== {2'd0, 1'b1}) begin
            bad_cnt++;
            $display("FAIL flush_count: got count=%0d ready=%b, required 0 1", count_o, ready_o);
        end
        if ({valid_o, op_o, bad_o} !== {1'b0, OpNop, 1'b0}) begin
            bad_cnt++;
            $display("FAIL flush_out: got valid=%b op=%h bad=%b, required 0 %h 0", valid_o, op_o, bad_o, OpNop);
        end
        stall_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({valid_o, count_o} !== {1'b0, 2'd0}) begin
                bad_cnt++;
                $display("FAIL flush_dropped c=%0d: got valid=%b count=%0d, required 0 0", c, valid_o, count_o);
            end
        end
        push(v[8], t);
        drain("postflush");
    endtask

    task automatic test_bad();
        int t;
`ifdef CPU_DECODE_STATS_EN
        logic [31:0] before;
        before = stat_decoded_o;
`endif
        for (int i = 0; i < 4; i++) push(bv[i], t);
        drain("bad");
`ifdef CPU_DECODE_STATS_EN
        total++;
        if (stat_decoded_o - before !== 32'd4) begin
            bad_cnt++;
            $display("FAIL stat_decoded: got delta %0d, required 4", stat_decoded_o - before);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int t;
        int slow;
        slow = 0;
        for (int i = 0; i < 9; i++) begin
            push(v[i], t);
            if (t != 1) slow++;
        end
        total++;
        if (slow !== 0) begin bad_cnt++; $display("FAIL throughput: got %0d delayed pushes, required 0", slow); end
        drain("b2b");
        fork
            begin
                for (int i = 0; i < 9; i++) push(v[i], t);
                for (int i = 0; i < 4; i++) push(bv[i], t);
            end
            begin
                repeat (30) begin
                    stall_i = 1'($urandom_range(0, 1));
                    tick();
                end
                stall_i = 1'b0;
            end
        join
        drain("random_stall");
    endtask

    task automatic test_async_reset();
        int t;
        stall_i = 1'b1;
        push(v[1], t);
        push(v[2], t);
        #3 rst_i = 1'b1;
        #1;
        exp_q.delete();
        total++;
        if ({valid_o, op_o, count_o, ready_o} !== {1'b0, OpNop, 2'd0, 1'b0}) begin
            bad_cnt++;
            $display("FAIL async_reset: got valid=%b op=%h count=%0d ready=%b, required 0 %h 0 0",
                     valid_o, op_o, count_o, ready_o, OpNop);
        end
        tick();
        rst_i = 1'b0;
        stall_i = 1'b0;
        tick();
    endtask

    initial begin
        v[0] = mk(16'h0223, 32'h1111_1111, 32'h100, OpMov,  4'h2, 4'h3, 32'h0, 1'b0, 8'h05);
        v[1] = mk(16'h0140, 32'hDEAD_BEEF, 32'h104, OpLdiL, 4'h4, 4'h0, 32'hDEAD_BEEF, 1'b0, 8'h41);
        v[2] = mk(16'hC3FF, 32'h5555,      32'h10A, OpBeq,  4'h3, 4'hF, 32'hFFFF_FFFE, 1'b0, 8'h20);
        v[3] = mk(16'h8512, 32'h7777,      32'h10C, OpInc,  4'h5, 4'h2, 32'h12, 1'b0, 8'h03);
        v[4] = mk(16'hC805, 32'h0,         32'h10E, OpBlt,  4'h8, 4'h5, 32'h0A, 1'b0, 8'h20);
        v[5] = mk(16'hE401, 32'h0,         32'h110, OpBleu, 4'h4, 4'h1, 32'h02, 1'b0, 8'h20);
        v[6] = mk(16'hB7A5, 32'h9999,      32'h112, OpSsr,  4'h7, 4'h5, 32'hA5, 1'b0, 8'h02);
        v[7] = mk(16'h3912, 32'hCAFE_F00D, 32'h114, OpStoS, 4'h1, 4'h2, 32'hCAFE_F00D, 1'b0, 8'h56);
        v[8] = mk(16'h0534, 32'h1234,      32'h118, OpAddL, 4'h3, 4'h4, 32'h0, 1'b0, 8'h07);
        bv[0] = mk(16'h0F00, 32'h1, 32'h200, OpBad, 4'h0, 4'h0, 32'h0, 1'b1, 8'h00);
        bv[1] = mk(16'hE800, 32'h2, 32'h204, OpBad, 4'h8, 4'h0, 32'h0, 1'b1, 8'h00);
        bv[2] = mk(16'h3E57, 32'h3, 32'h208, OpBad, 4'h5, 4'h7, 32'h0, 1'b1, 8'h00);
        bv[3] = mk(16'h1466, 32'h4, 32'h20C, OpBad, 4'h6, 4'h6, 32'h0, 1'b1, 8'h00);

        test_reset();
        test_decode();
        test_stall_fill();
        test_flush();
        test_bad();
        test_back_to_back();
        test_async_reset();
        test_decode();

        $display("test done: total=%0d bad=%0d", total, bad_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
